int_stim_gen: RTL and testbench

Parametrised interrupt stimulus generator for CPU-level testbenches. It watches the CPU's committed-PC output (`addr`) and drives the external `interrupt` line. It has NCH independent channels. Each channel holds a trigger PC, a trigger delay, a pulse length and a shot budget, so a single run can raise interrupts at several PCs, at controlled offsets, and more than once. It sits beside `mips` in the top-level bench and is programmed through a simple write port before or during the run.

---
 rtl/int_stim_pkg.sv | 25 ++
 rtl/int_stim_chan.sv | 159 +++++++++++++++
 rtl/int_stim_gen.sv | 64 ++++++
 tb/tb_int_stim_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/int_stim_pkg.sv
// Shared types, default widths and helpers for the interrupt stimulus generator.
// Optional feature macro used across the slice: INT_STIM_ACK_EN (acknowledge / level mode).
package int_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_PULSE = 2'd2,
    ST_REARM = 2'd3
  } chan_state_e;

  localparam int DEF_NCH    = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DLY_W  = 8;
  localparam int DEF_LEN_W  = 4;
  localparam int DEF_SHOT_W = 4;

  // An all-ones shot budget at field width means the channel never runs out.
  function automatic logic shots_unlimited(input logic [31:0] shots, input int unsigned w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return (shots & mask) == mask;
  endfunction

endpackage

// File: rtl/int_stim_chan.sv
// One interrupt stimulus channel: trigger PC, delay, pulse length and shot budget.
// INT_STIM_ACK_EN adds a level mode held until acknowledged, and ack as early terminate.
module int_stim_chan
  import int_stim_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DLY_W  = DEF_DLY_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int SHOT_W = DEF_SHOT_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              cfg_we_i,
  input  logic [ADDR_W-1:0] cfg_pc_i,
  input  logic [DLY_W-1:0]  cfg_delay_i,
  input  logic [LEN_W-1:0]  cfg_len_i,
  input  logic [SHOT_W-1:0] cfg_shots_i,
`ifdef INT_STIM_ACK_EN
  input  logic              cfg_level_i,
  input  logic              irq_ack_i,
`endif
  output logic              irq_o,
  output logic              active_o
);

  localparam int CNT_W = (DLY_W > LEN_W) ? DLY_W : LEN_W;

  chan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DLY_W-1:0]  delay_q, delay_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [SHOT_W-1:0] shots_q, shots_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              irq_q, irq_d;
  logic              active_q;
  logic              match_s;
  logic              pulse_end_s;
`ifdef INT_STIM_ACK_EN
  logic              level_q, level_d;
`endif

  assign match_s = (addr_i == pc_q) && (shots_q != {SHOT_W{1'b0}});

`ifdef INT_STIM_ACK_EN
  assign pulse_end_s = level_q ? irq_ack_i : (irq_ack_i || (cnt_q == {CNT_W{1'b0}}));
`else
  assign pulse_end_s = (cnt_q == {CNT_W{1'b0}});
`endif

  // Next-state logic; a config write overrides whatever the channel was doing.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    delay_d = delay_q;
    len_d   = len_q;
    shots_d = shots_q;
    cnt_d   = cnt_q;
    irq_d   = irq_q;
`ifdef INT_STIM_ACK_EN
    level_d = level_q;
`endif
    if (cfg_we_i) begin
      pc_d    = cfg_pc_i;
      delay_d = cfg_delay_i;
      len_d   = cfg_len_i;
      shots_d = cfg_shots_i;
      cnt_d   = {CNT_W{1'b0}};
      irq_d   = 1'b0;
      state_d = ST_IDLE;
`ifdef INT_STIM_ACK_EN
      level_d = cfg_level_i;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (match_s && (delay_q == {DLY_W{1'b0}})) begin
            state_d = ST_PULSE;
            irq_d   = 1'b1;
            cnt_d   = CNT_W'(len_q);
          end else if (match_s) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(delay_q - DLY_W'(1));
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_d = ST_PULSE;
            irq_d   = 1'b1;
            cnt_d   = CNT_W'(len_q);
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        ST_PULSE: begin
          if (pulse_end_s) begin
            state_d = ST_REARM;
            irq_d   = 1'b0;
            if (!shots_unlimited(32'(shots_q), SHOT_W) && (shots_q != {SHOT_W{1'b0}})) begin
              shots_d = shots_q - SHOT_W'(1);
            end else begin
              shots_d = shots_q;
            end
          end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_REARM: begin
          if (addr_i != pc_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_REARM;
          end
        end
        default: begin
          state_d = ST_IDLE;
          irq_d   = 1'b0;
        end
      endcase
    end
  end

  // Channel state registers, updated on the falling edge of the bench clock.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      pc_q     <= {ADDR_W{1'b0}};
      delay_q  <= {DLY_W{1'b0}};
      len_q    <= {LEN_W{1'b0}};
      shots_q  <= {SHOT_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      irq_q    <= 1'b0;
      active_q <= 1'b0;
`ifdef INT_STIM_ACK_EN
      level_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      delay_q  <= delay_d;
      len_q    <= len_d;
      shots_q  <= shots_d;
      cnt_q    <= cnt_d;
      irq_q    <= irq_d;
      active_q <= (state_d != ST_IDLE);
`ifdef INT_STIM_ACK_EN
      level_q  <= level_d;
`endif
    end
  end

  assign irq_o    = irq_q;
  assign active_o = active_q;

endmodule

// File: rtl/int_stim_gen.sv
// Multi-channel interrupt stimulus generator watching the CPU committed PC.
// Define INT_STIM_ACK_EN to add the irq_ack / cfg_level ports.
module int_stim_gen
  import int_stim_pkg::*;
#(
  parameter  int NCH    = DEF_NCH,
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int DLY_W  = DEF_DLY_W,
  parameter  int LEN_W  = DEF_LEN_W,
  parameter  int SHOT_W = DEF_SHOT_W,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ADDR_W-1:0] cfg_pc,
  input  logic [DLY_W-1:0]  cfg_delay,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [SHOT_W-1:0] cfg_shots,
`ifdef INT_STIM_ACK_EN
  input  logic              cfg_level,
  input  logic [NCH-1:0]    irq_ack,
`endif
  output logic [NCH-1:0]    irq_vec,
  output logic              interrupt,
  output logic              busy
);

  logic [NCH-1:0] active_s;

  // Out-of-range channel indices decode to no write strobe at all.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic we_s;
    assign we_s = cfg_we && (cfg_ch == CH_W'(i));

    int_stim_chan #(
      .ADDR_W(ADDR_W),
      .DLY_W (DLY_W),
      .LEN_W (LEN_W),
      .SHOT_W(SHOT_W)
    ) u_chan (
      .clk_i      (clk),
      .rst_ni     (reset),
      .addr_i     (addr),
      .cfg_we_i   (we_s),
      .cfg_pc_i   (cfg_pc),
      .cfg_delay_i(cfg_delay),
      .cfg_len_i  (cfg_len),
      .cfg_shots_i(cfg_shots),
`ifdef INT_STIM_ACK_EN
      .cfg_level_i(cfg_level),
      .irq_ack_i  (irq_ack[i]),
`endif
      .irq_o      (irq_vec[i]),
      .active_o   (active_s[i])
    );
  end

  assign interrupt = |irq_vec;
  assign busy      = |active_s;

endmodule

// File: tb/tb_int_stim_gen.sv
// Self-checking bench for int_stim_gen: directed scenarios plus random traffic vs a timeline model.
module tb_int_stim_gen;

  localparam int NCH = 4;
  localparam logic [31:0] IDLE_PC = 32'h0000_1000;

  logic          clk;
  logic          reset;
  logic [31:0]   addr;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [31:0]   cfg_pc;
  logic [7:0]    cfg_delay;
  logic [3:0]    cfg_len;
  logic [3:0]    cfg_shots;
  logic          cfg_level_r;
  logic [NCH-1:0] ack_r;
  logic [NCH-1:0] irq_vec;
  logic          interrupt;
  logic          busy;

  int_stim_gen #(.NCH(NCH)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_pc   (cfg_pc),
    .cfg_delay(cfg_delay),
    .cfg_len  (cfg_len),
    .cfg_shots(cfg_shots),
`ifdef INT_STIM_ACK_EN
    .cfg_level(cfg_level_r),
    .irq_ack  (ack_r),
`endif
    .irq_vec  (irq_vec),
    .interrupt(interrupt),
    .busy     (busy)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;

  // Timeline model: each channel is either idle, has a scheduled pulse window, or waits for addr to leave.
  logic [31:0] m_pc    [NCH];
  int          m_dly   [NCH];
  int          m_len   [NCH];
  int          m_shots [NCH];
  bit          m_lvl   [NCH];
  bit          m_pend  [NCH];
  bit          m_leave [NCH];
  int          m_start [NCH];
  int          m_stop  [NCH];
  logic [NCH-1:0] exp_vec;
  logic        exp_busy;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pc[i] = 32'd0; m_dly[i] = 0; m_len[i] = 0; m_shots[i] = 0; m_lvl[i] = 1'b0;
      m_pend[i] = 1'b0; m_leave[i] = 1'b0; m_start[i] = 0; m_stop[i] = 0;
    end
    exp_vec = '0;
    exp_busy = 1'b0;
  endtask

  task automatic model_edge();
    for (int i = 0; i < NCH; i++) begin
      if (cfg_we && (int'(cfg_ch) == i)) begin
        m_pc[i] = cfg_pc; m_dly[i] = int'(cfg_delay); m_len[i] = int'(cfg_len);
        m_shots[i] = int'(cfg_shots); m_lvl[i] = cfg_level_r;
        m_pend[i] = 1'b0; m_leave[i] = 1'b0;
      end else if (m_pend[i]) begin
        if ((!m_lvl[i] && edge_n == m_stop[i]) || (ack_r[i] && edge_n > m_start[i])) begin
          m_pend[i] = 1'b0;
          m_leave[i] = 1'b1;
          if (m_shots[i] != 15 && m_shots[i] != 0) m_shots[i]--;
        end
      end else if (m_leave[i]) begin
        if (addr != m_pc[i]) m_leave[i] = 1'b0;
      end else if (addr == m_pc[i] && m_shots[i] != 0) begin
        m_pend[i] = 1'b1;
        m_start[i] = edge_n + m_dly[i];
        m_stop[i] = edge_n + m_dly[i] + m_len[i] + 1;
      end
    end
    exp_busy = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      exp_vec[i] = m_pend[i] && (edge_n >= m_start[i]);
      if (m_pend[i] || m_leave[i]) exp_busy = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_edge();
    #1;
    check_eq("irq_vec", 32'(irq_vec), 32'(exp_vec));
    check_eq("interrupt", 32'(interrupt), 32'(|exp_vec));
    check_eq("busy", 32'(busy), 32'(exp_busy));
    edge_n++;
  endtask

  task automatic run(input int n, output int hi, output int first);
    hi = 0;
    first = -1;
    for (int k = 0; k < n; k++) begin
      step();
      if (interrupt) begin
        if (first < 0) first = k;
        hi++;
      end
    end
  endtask

  task automatic cfg_write(input int ch, input logic [31:0] pc, input int dly, input int len,
                           input int shots, input bit lvl);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_pc = pc; cfg_delay = 8'(dly);
    cfg_len = 4'(len); cfg_shots = 4'(shots); cfg_level_r = lvl;
    step();
    cfg_we = 1'b0; cfg_level_r = 1'b0;
  endtask

  task automatic mid_reset();
    reset = 1'b0;
    #1;
    check_eq("rst_irq_vec", 32'(irq_vec), 32'd0);
    check_eq("rst_interrupt", 32'(interrupt), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    model_reset();
    #2;
    reset = 1'b1;
  endtask

  logic [31:0] pool [4];
  int hi, first, hi2, first2;

  initial begin
    pool[0] = 32'h3000; pool[1] = 32'h3004; pool[2] = 32'h3008; pool[3] = 32'h300c;
    reset = 1'b0; addr = IDLE_PC; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_pc = 32'd0;
    cfg_delay = 8'd0; cfg_len = 4'd0; cfg_shots = 4'd0; cfg_level_r = 1'b0; ack_r = '0;
    model_reset();
    #2;
    check_eq("reset_irq_vec", 32'(irq_vec), 32'd0);
    check_eq("reset_interrupt", 32'(interrupt), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;

    // Single shot, delay 0, len 5: six cycles high from the match edge, no second pulse.
    cfg_write(0, 32'h301c, 0, 5, 1, 1'b0);
    addr = 32'h301c; step();
    check_eq("t1_rise", 32'(interrupt), 32'd1);
    addr = IDLE_PC; run(10, hi, first);
    check_eq("t1_len", 32'(hi + 1), 32'd6);
    addr = 32'h301c; run(1, hi, first);
    addr = IDLE_PC; run(8, hi2, first2);
    check_eq("t1_no_refire", 32'(hi + hi2), 32'd0);

    // Delay 3, len 0, two shots: held addr fires once, leave+return fires again, third visit nothing.
    cfg_write(1, 32'h3040, 3, 0, 2, 1'b0);
    addr = 32'h3040; run(10, hi, first);
    check_eq("t2_hold_hi", 32'(hi), 32'd1);
    check_eq("t2_hold_at", 32'(first), 32'd3);
    addr = IDLE_PC; run(2, hi, first);
    addr = 32'h3040; run(6, hi, first);
    check_eq("t2_second_hi", 32'(hi), 32'd1);
    check_eq("t2_second_at", 32'(first), 32'd3);
    addr = IDLE_PC; run(2, hi, first);
    addr = 32'h3040; run(6, hi, first);
    check_eq("t2_third_hi", 32'(hi), 32'd0);
    addr = IDLE_PC; run(2, hi, first);

    // Two channels on the same PC: simultaneous assertion, OR lasts the longer pulse.
    cfg_write(0, 32'h3000, 0, 1, 1, 1'b0);
    cfg_write(2, 32'h3000, 0, 3, 1, 1'b0);
    addr = 32'h3000; step();
    check_eq("t3_vec", 32'(irq_vec), 32'h5);
    addr = IDLE_PC; run(8, hi, first);
    check_eq("t3_len", 32'(hi + 1), 32'd4);

    // Config write in the second cycle of a pulse aborts it.
    cfg_write(0, 32'h301c, 0, 5, 1, 1'b0);
    addr = 32'h301c; step();
    addr = IDLE_PC; step();
    cfg_write(0, 32'h301c, 0, 5, 0, 1'b0);
    check_eq("t4_abort_int", 32'(interrupt), 32'd0);
    check_eq("t4_abort_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-pulse, then nothing fires until reprogrammed.
    cfg_write(0, 32'h301c, 0, 5, 1, 1'b0);
    addr = 32'h301c; step();
    addr = IDLE_PC; step();
    mid_reset();
    addr = 32'h301c; run(6, hi, first);
    addr = 32'h0; run(4, hi2, first2);
    check_eq("t5_post_reset", 32'(hi + hi2), 32'd0);
    addr = IDLE_PC;

`ifdef INT_STIM_ACK_EN
    // Level-mode channel held until acknowledged 20 cycles after assertion.
    cfg_write(3, 32'h3100, 0, 0, 1, 1'b1);
    addr = 32'h3100; step();
    addr = IDLE_PC; run(19, hi, first);
    ack_r = 4'b1000; step();
    check_eq("t6_ack_drop", 32'(interrupt), 32'd0);
    ack_r = '0;
    check_eq("t6_len", 32'(hi + 1), 32'd20);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      cfg_we = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        cfg_we = 1'b1;
        cfg_ch = 2'($urandom_range(0, NCH - 1));
        cfg_pc = pool[$urandom_range(0, 3)];
        cfg_delay = 8'($urandom_range(0, 4));
        cfg_len = 4'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0: cfg_shots = 4'd0;
          1: cfg_shots = 4'd1;
          2: cfg_shots = 4'd2;
          default: cfg_shots = 4'd15;
        endcase
`ifdef INT_STIM_ACK_EN
        cfg_level_r = 1'($urandom_range(0, 1));
`endif
      end
      addr = ($urandom_range(0, 3) == 0) ? IDLE_PC : pool[$urandom_range(0, 3)];
`ifdef INT_STIM_ACK_EN
      ack_r = ($urandom_range(0, 9) == 0) ? NCH'($urandom_range(0, 15)) : '0;
`endif
      step();
    end
    cfg_we = 1'b0;
    ack_r = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
